// File: rtl/trim_sweep_ctrl_pkg.sv
// trim_pkg: shared trim-code width, nominal BGR code and sequencer state encoding
package trim_pkg;
  localparam int TRIM_W = 12;
  localparam logic [TRIM_W-1:0] NOMINAL_CODE = 12'd1983;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_REQ   = 3'd2,
    S_SHIFT = 3'd3,
    S_DWELL = 3'd4,
    S_NEXT  = 3'd5
  } state_t;
endpackage

// File: rtl/trim_sweep_ctrl_sync_edge.sv
// sync_edge: 2-flop synchronizer with registered-history rise/fall pulses
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {d, s1, s2};
  assign q = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/trim_sweep_ctrl.sv
// trim_sweep_ctrl: sequences manual or swept trim codes into the serial shifter with settle dwell
module trim_sweep_ctrl
  import trim_pkg::*;
#(
  parameter int               WIDTH        = TRIM_W,
  parameter logic [WIDTH-1:0] CODE_MIN     = '0,
  parameter logic [WIDTH-1:0] CODE_MAX     = '1,
  parameter logic [WIDTH-1:0] STEP         = 1,
  parameter logic [31:0]      DWELL_CYCLES = 32'd50000000,
  parameter logic [31:0]      REQ_TIMEOUT  = 32'd1000000
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic             GO,
  input  logic             ABORT,
  input  logic             MODE,
  input  logic [WIDTH-1:0] SW,
  input  logic             BUSY,
  output logic [WIDTH-1:0] TRIM_OUT,
  output logic             START,
  output logic             ACTIVE,
  output logic             DWELLING,
  output logic             DONE,
  output logic             ERR
);
  state_t state;
  logic mode_l;
  logic [31:0] tcnt, dcnt;
  logic [WIDTH:0] sum;
  logic go_p, go_q, go_fall, abort_q, abort_rise, abort_fall, busy_q, busy_rise, busy_fall;
  logic unused_edges;
  sync_edge u_go (.clk(CLOCK_50), .rst_n(RST_N), .d(GO), .q(go_q), .rise(go_p), .fall(go_fall));
  sync_edge u_abort (.clk(CLOCK_50), .rst_n(RST_N), .d(ABORT), .q(abort_q), .rise(abort_rise), .fall(abort_fall));
  sync_edge u_busy (.clk(CLOCK_50), .rst_n(RST_N), .d(BUSY), .q(busy_q), .rise(busy_rise), .fall(busy_fall));
  assign unused_edges = &{1'b0, go_q, go_fall, abort_rise, abort_fall, busy_q};
  // one extra bit so a step past the top of the code range is seen as a carry, never a wrap
  assign sum = {1'b0, TRIM_OUT} + {1'b0, STEP};
  always_ff @(posedge CLOCK_50 or negedge RST_N)
    if (!RST_N) begin
      state <= S_IDLE;
      TRIM_OUT <= '0;
      START <= 1'b0;
      ACTIVE <= 1'b0;
      DWELLING <= 1'b0;
      DONE <= 1'b0;
      ERR <= 1'b0;
      mode_l <= 1'b0;
      tcnt <= '0;
      dcnt <= '0;
    end else begin
      DONE <= 1'b0;
      if (state != S_IDLE && abort_q) begin
        state <= S_IDLE;
        START <= 1'b0;
        ACTIVE <= 1'b0;
        DWELLING <= 1'b0;
      end else
        case (state)
          S_IDLE:
            if (go_p && !abort_q) begin
              ERR <= 1'b0;
              TRIM_OUT <= MODE ? CODE_MIN : SW;
              mode_l <= MODE;
              ACTIVE <= 1'b1;
              state <= S_LOAD;
            end
          S_LOAD: begin
            START <= 1'b1;
            tcnt <= '0;
            state <= S_REQ;
          end
          S_REQ:
            if (busy_rise) begin
              START <= 1'b0;
              state <= S_SHIFT;
            end else if (tcnt == REQ_TIMEOUT - 1) begin
              START <= 1'b0;
              ERR <= 1'b1;
              ACTIVE <= 1'b0;
              state <= S_IDLE;
            end else tcnt <= tcnt + 1;
          S_SHIFT:
            if (busy_fall) begin
              dcnt <= '0;
              DWELLING <= 1'b1;
              state <= S_DWELL;
            end
          S_DWELL:
            if (dcnt == DWELL_CYCLES - 1) begin
              DWELLING <= 1'b0;
              DONE <= !mode_l;
              ACTIVE <= mode_l;
              state <= mode_l ? S_NEXT : S_IDLE;
            end else dcnt <= dcnt + 1;
          S_NEXT:
            if (sum[WIDTH] || sum > {1'b0, CODE_MAX}) begin
              DONE <= 1'b1;
              ACTIVE <= 1'b0;
              state <= S_IDLE;
            end else begin
              TRIM_OUT <= sum[WIDTH-1:0];
              state <= S_LOAD;
            end
          default: begin
            START <= 1'b0;
            ACTIVE <= 1'b0;
            DWELLING <= 1'b0;
            state <= S_IDLE;
          end
        endcase
    end
endmodule

// File: tb/tb_trim_sweep_ctrl.sv
// tb_trim_sweep_ctrl: directed checks of manual, sweep, wrap, timeout, abort and async reset
module tb_trim_sweep_ctrl;
  import trim_pkg::*;
  localparam int SA = 0, SS = 1, SB = 2, SD = 3, SAW = 4;
  logic clk = 0, rst_n, go, abort, mode, busy, go_w, busy_w, bfm_en;
  logic [11:0] sw, trim_out, trim_out_w;
  logic start, active, dwelling, done, err;
  logic start_w, active_w, dwelling_w, done_w, err_w;
  logic start_q = 0, start_w_q = 0;
  logic [11:0] codes[$], codes_w[$];
  int dones = 0, dones_w = 0, tests = 0, fails = 0, n, d0, b0;
  always #10 clk = ~clk;
  trim_sweep_ctrl #(.CODE_MIN(12'd10), .CODE_MAX(12'd14), .STEP(12'd2),
    .DWELL_CYCLES(32'd100), .REQ_TIMEOUT(32'd50)) u_dut (
    .CLOCK_50(clk), .RST_N(rst_n), .GO(go), .ABORT(abort), .MODE(mode), .SW(sw), .BUSY(busy),
    .TRIM_OUT(trim_out), .START(start), .ACTIVE(active), .DWELLING(dwelling), .DONE(done), .ERR(err));
  trim_sweep_ctrl #(.CODE_MIN(12'd4094), .CODE_MAX(12'd4095), .STEP(12'd3),
    .DWELL_CYCLES(32'd20), .REQ_TIMEOUT(32'd50)) u_wrap (
    .CLOCK_50(clk), .RST_N(rst_n), .GO(go_w), .ABORT(1'b0), .MODE(1'b1), .SW(12'd0), .BUSY(busy_w),
    .TRIM_OUT(trim_out_w), .START(start_w), .ACTIVE(active_w), .DWELLING(dwelling_w), .DONE(done_w), .ERR(err_w));
  // shifter models: BUSY rises 20 cycles after START, falls 200 cycles later
  initial busy = 0;
  always begin
    @(posedge clk);
    if (start && bfm_en && !busy) begin
      repeat (20) @(posedge clk);
      #1 busy = 1;
      repeat (200) @(posedge clk);
      #1 busy = 0;
    end
  end
  initial busy_w = 0;
  always begin
    @(posedge clk);
    if (start_w && !busy_w) begin
      repeat (20) @(posedge clk);
      #1 busy_w = 1;
      repeat (200) @(posedge clk);
      #1 busy_w = 0;
    end
  end
  always @(negedge clk) begin
    if (start && !start_q) codes.push_back(trim_out);
    if (start_w && !start_w_q) codes_w.push_back(trim_out_w);
    start_q = start;
    start_w_q = start_w;
    if (done) dones++;
    if (done_w) dones_w++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  function automatic logic pick(input int s);
    return s == SA ? active : s == SS ? start : s == SB ? busy : s == SD ? dwelling : active_w;
  endfunction
  task automatic wait_until(input int s, input logic v, input int bound, input string tag);
    int k = 0;
    while (pick(s) !== v && k < bound) begin
      cyc(1);
      k++;
    end
    chk(tag, {31'd0, pick(s)}, {31'd0, v});
  endtask
  task automatic count_high(input int s, input int bound, output int k);
    k = 0;
    while (pick(s) === 1'b1 && k < bound) begin
      cyc(1);
      k++;
    end
  endtask
  task automatic pulse_go;
    go = 1;
    cyc(2);
    go = 0;
  endtask
  initial begin
    rst_n = 0; go = 0; abort = 0; mode = 0; sw = 0; go_w = 0; bfm_en = 1;
    cyc(3);
    chk("reset_outputs", {14'd0, trim_out, start, active, dwelling, done, err}, 0);
    @(negedge clk) rst_n = 1;
    cyc(2);
    // manual shot
    mode = 0; sw = NOMINAL_CODE; d0 = dones; b0 = codes.size();
    pulse_go();
    wait_until(SA, 1, 20, "man_active");
    chk("man_load_trim", trim_out, 1983);
    chk("man_load_start", start, 0);
    cyc(1);
    chk("man_req_start", start, 1);
    wait_until(SB, 1, 100, "man_busy_rise");
    cyc(2);
    chk("man_start_hold", start, 1);
    cyc(1);
    chk("man_start_drop", start, 0);
    wait_until(SD, 1, 400, "man_dwell_seen");
    count_high(SD, 1000, n);
    chk("man_dwell_len", n, 100);
    chk("man_done_pulse", done, 1);
    chk("man_idle", active, 0);
    chk("man_trim_hold", trim_out, 1983);
    cyc(2);
    chk("man_done_count", dones - d0, 1);
    chk("man_start_count", codes.size() - b0, 1);
    // sweep 10,12,14
    mode = 1; d0 = dones; b0 = codes.size();
    pulse_go();
    wait_until(SA, 1, 20, "swp_active");
    wait_until(SA, 0, 5000, "swp_finish");
    chk("swp_start_count", codes.size() - b0, 3);
    chk("swp_code0", codes[b0], 10);
    chk("swp_code1", codes[b0+1], 12);
    chk("swp_code2", codes[b0+2], 14);
    cyc(2);
    chk("swp_done_count", dones - d0, 1);
    chk("swp_trim_last", trim_out, 14);
    // request timeout
    bfm_en = 0; mode = 0; sw = 12'd5; d0 = dones;
    pulse_go();
    wait_until(SS, 1, 20, "to_start");
    count_high(SS, 200, n);
    chk("to_start_len", n, 50);
    chk("to_err", err, 1);
    chk("to_idle", active, 0);
    cyc(10);
    chk("to_err_sticky", err, 1);
    chk("to_no_done", dones - d0, 0);
    // retry clears ERR, then abort in SHIFT
    bfm_en = 1; d0 = dones;
    pulse_go();
    wait_until(SA, 1, 20, "retry_active");
    chk("retry_err_clear", err, 0);
    wait_until(SB, 1, 100, "ab_busy_rise");
    wait_until(SS, 0, 10, "ab_in_shift");
    abort = 1;
    count_high(SA, 10, n);
    chk("ab_shift_latency", n <= 4, 1);
    chk("ab_shift_start", start, 0);
    chk("ab_shift_active", active, 0);
    abort = 0;
    wait_until(SB, 0, 400, "ab_busy_done");
    cyc(5);
    chk("ab_shift_no_done", dones - d0, 0);
    chk("ab_shift_err", err, 0);
    // sweep with ignored GO and MODE change, abort in second DWELL
    mode = 1; d0 = dones; b0 = codes.size();
    pulse_go();
    wait_until(SS, 1, 20, "ig_start");
    mode = 0; sw = 12'd777;
    wait_until(SB, 1, 100, "ig_busy");
    pulse_go();
    wait_until(SD, 1, 400, "ig_dwell1");
    wait_until(SD, 0, 200, "ig_dwell1_end");
    wait_until(SD, 1, 600, "ig_dwell2");
    chk("ig_start_count", codes.size() - b0, 2);
    chk("ig_code1", codes[b0+1], 12);
    chk("ig_trim", trim_out, 12);
    abort = 1;
    count_high(SA, 10, n);
    chk("ab_dwell_latency", n <= 4, 1);
    chk("ab_dwell_dwelling", dwelling, 0);
    chk("ab_dwell_start", start, 0);
    abort = 0;
    cyc(3);
    chk("ab_dwell_no_done", dones - d0, 0);
    // ABORT beats GO in IDLE
    abort = 1; go = 1;
    cyc(2);
    go = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      n += active;
    end
    chk("abort_wins_idle", n, 0);
    abort = 0;
    cyc(3);
    // async reset mid-DWELL
    mode = 0; sw = 12'd100;
    pulse_go();
    wait_until(SD, 1, 400, "rst_dwell");
    cyc(5);
    #3 rst_n = 0;
    #1 chk("rst_async_outputs", {14'd0, trim_out, start, active, dwelling, done, err}, 0);
    @(negedge clk) rst_n = 1;
    cyc(2);
    mode = 1; b0 = codes.size(); d0 = dones;
    pulse_go();
    wait_until(SA, 1, 20, "rst_restart");
    chk("rst_restart_trim", trim_out, 10);
    wait_until(SA, 0, 5000, "rst_sweep_finish");
    chk("rst_first_code", codes[b0], 10);
    chk("rst_start_count", codes.size() - b0, 3);
    cyc(2);
    chk("rst_done_count", dones - d0, 1);
    // carry out of the top code ends the sweep
    go_w = 1;
    cyc(2);
    go_w = 0;
    wait_until(SAW, 1, 20, "wrap_active");
    wait_until(SAW, 0, 2000, "wrap_finish");
    cyc(2);
    chk("wrap_start_count", codes_w.size(), 1);
    chk("wrap_code", codes_w[0], 4094);
    chk("wrap_done_count", dones_w, 1);
    chk("wrap_trim_hold", trim_out_w, 4094);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/trim_sweep_ctrl.md
Name: trim_sweep_ctrl

Overview:
- Upstream sequencer for the serial trim-code shifter that loads 12-bit codes into the BGR test chip.
- In manual mode it sends one switch-selected code per GO press.
- In sweep mode it steps codes from CODE_MIN to CODE_MAX. After each code it waits for the shifter to finish, then dwells a fixed settling time so the BGR output can be measured.
- It drives the shifter's code input and START, and observes the shifter's BUSY.

Parameters:
- WIDTH, 12: trim code width.
- CODE_MIN, 12'd0: first sweep code.
- CODE_MAX, 12'd4095: last sweep code (inclusive).
- STEP, 12'd1: sweep increment; must be ≥1.
- DWELL_CYCLES, 32'd50000000: CLOCK_50 cycles of settling after each shift completes (1 s).
- REQ_TIMEOUT, 32'd1000000: cycles to wait for BUSY to rise after START before flagging an error.

Ports:
- CLOCK_50, in, 1: 50 MHz system clock.
- RST_N, in, 1: asynchronous, active-low reset.
- GO, in, 1: asynchronous push-button start request, active high.
- ABORT, in, 1: asynchronous abort, active high.
- MODE, in, 1: 0 = manual (single code), 1 = sweep.
- SW, in, WIDTH: manual trim code.
- BUSY, in, 1: shifter busy; asynchronous to CLOCK_50 (slow divided-clock domain).
- TRIM_OUT, out, WIDTH: code presented to the shifter.
- START, out, 1: shift request to the shifter.
- ACTIVE, out, 1: high in every state except IDLE.
- DWELLING, out, 1: high only in DWELL; used as the measurement strobe.
- DONE, out, 1: one-cycle pulse at normal completion of a manual shot or a full sweep.
- ERR, out, 1: sticky request-timeout flag.

Behaviour:
- Reset (RST_N=0, asynchronous) forces all of the following immediately, including mid-operation:
  - state=IDLE, TRIM_OUT=0, START=0, ACTIVE=0, DWELLING=0, DONE=0, ERR=0;
  - all counters and synchronizers to 0.
- Input conditioning:
  - GO, ABORT and BUSY each pass through a 2-flop synchronizer.
  - GO is rising-edge detected, giving a 1-cycle go_p.
  - BUSY is edge detected, giving busy_rise and busy_fall.
  - Each edge event therefore occurs 3 cycles after the pin transition.
- States: IDLE, LOAD, REQ, SHIFT, DWELL, NEXT.
- IDLE:
  - START=0.
  - On go_p: clear ERR, then go to LOAD.
  - TRIM_OUT is latched on go_p: SW if MODE=0, CODE_MIN if MODE=1.
  - MODE is also latched on go_p; later changes to MODE have no effect until the next go_p.
- LOAD: one cycle so TRIM_OUT is stable before START; then go to REQ.
- REQ:
  - START=1 and the timeout counter increments.
  - On busy_rise: START=0 on the next cycle, go to SHIFT.
  - If the counter reaches REQ_TIMEOUT-1 first: START=0, ERR=1, go to IDLE, no DONE.
- SHIFT:
  - TRIM_OUT is held constant.
  - On busy_fall: go to DWELL with the dwell counter cleared.
- DWELL:
  - DWELLING=1; the counter counts 0..DWELL_CYCLES-1.
  - After the terminal count, in manual mode: DONE pulse, go to IDLE.
  - After the terminal count, in sweep mode: go to NEXT.
- NEXT:
  - Width rule: the addition TRIM_OUT+STEP is computed WIDTH+1 bits wide.
  - If the sum is greater than CODE_MAX, or the carry bit is set (wrap): DONE pulse, go to IDLE; TRIM_OUT keeps the last code sent.
  - Otherwise: TRIM_OUT is set to the sum, go to LOAD.
  - Consequence: the code sequence never wraps past 4095.
- ABORT (synchronized level) in any non-IDLE state:
  - START=0 next cycle, go to IDLE, no DONE, ERR unchanged.
  - If aborted in SHIFT, the shifter is left to finish on its own; no BUSY wait is required.
- go_p outside IDLE is ignored.
- ABORT and go_p in the same cycle while in IDLE: ABORT wins and stays IDLE.
- ACTIVE = (state != IDLE).
- All outputs are registered.
- Boundary case: CODE_MIN == CODE_MAX sends exactly one code, then asserts DONE.

Decomposition:
- Shared package trim_pkg holds:
  - state encoding localparams (3-bit);
  - TRIM_W=12;
  - nominal code 12'd1983 (0111_1011_1111), which the shifter also uses.
- One sub-module, sync_edge: 2-flop synchronizer plus rising/falling pulse outputs.
  - Instantiated three times: GO, ABORT, BUSY.

Test Plan:
- Manual shot: MODE=0, SW=12'd1983, pulse GO, BFM raises BUSY 20 cycles after START and drops it 200 cycles later.
  - TRIM_OUT=1983 from LOAD onward; START drops 1 cycle after busy_rise.
  - DWELLING high for exactly DWELL_CYCLES (set to 100); one DONE pulse, then IDLE.
- Sweep: CODE_MIN=10, CODE_MAX=14, STEP=2.
  - Codes sent are 10, 12, 14; exactly 3 START handshakes; DONE once after code 14.
- Wrap boundary: CODE_MIN=4094, CODE_MAX=4095, STEP=3.
  - Only 4094 is sent; DONE; TRIM_OUT stays 4094.
- Timeout: BFM never raises BUSY, REQ_TIMEOUT=50.
  - START falls after 50 REQ cycles; ERR=1 sticky; no DONE; next GO clears ERR.
- Abort in SHIFT and DWELL: assert ABORT.
  - Within 4 cycles: IDLE, START=0, ACTIVE=0, no DONE.
  - A GO during an active sweep is ignored.
- Async reset mid-DWELL: drop RST_N between clock edges.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a GO starts cleanly from CODE_MIN.
